// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the multi-port register file.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NRD_DEF   = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bundle: write port, NRD read ports, soft-clear request and busy flag.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NRD   = NRD_DEF
);
  localparam int AW = $clog2(DEPTH);

  logic                      REG_clr;
  logic                      REG_enable;
  logic [AW-1:0]             REG_wa;
  logic [XLEN-1:0]           REG_wd;
  logic [NRD-1:0][AW-1:0]    REG_adr;
  logic [NRD-1:0][XLEN-1:0]  REG_rs;
  logic                      REG_busy;

  modport master (
    output REG_clr, REG_enable, REG_wa, REG_wd, REG_adr,
    input  REG_rs, REG_busy
  );

  modport slave (
    input  REG_clr, REG_enable, REG_wa, REG_wd, REG_adr,
    output REG_rs, REG_busy
  );
endinterface

// File: rtl/reg_clr_seq.sv
// Clear sequencer: sweeps every entry to zero over DEPTH cycles after reset or a clear pulse.
// A clear pulse mid-sweep restarts at entry 0; busy is a flop mirroring state == CLEAR.
module reg_clr_seq
  import reg_file_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     busy,
  output logic                     clr_we,
  output logic [$clog2(DEPTH)-1:0] clr_idx
);
  localparam int AW = $clog2(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;
  logic          r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_idx   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= (w_state_nxt == CLEAR);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    clr_we      = 1'b0;
    case (r_state)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr) begin
          w_idx_nxt = '0;
        end else if (r_idx == AW'(DEPTH - 1)) begin
          w_state_nxt = READY;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + AW'(1);
        end
      end
      READY: begin
        if (clr) begin
          w_state_nxt = CLEAR;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign busy    = r_busy;
  assign clr_idx = r_idx;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, NRD zero-latency read ports, x0 hard-wired to zero.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NRD   = NRD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            w_busy;
  logic            w_clr_we;
  logic [AW-1:0]   w_clr_idx;
  logic            w_we;
  logic [XLEN-1:0] r_ram [DEPTH];

  reg_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.REG_clr),
    .busy    (w_busy),
    .clr_we  (w_clr_we),
    .clr_idx (w_clr_idx)
  );

  // Writes only land when idle; anything coinciding with reset or a clear request is discarded.
  assign w_we = !w_busy && bus.REG_enable && (bus.REG_wa != '0) && !bus.REG_clr && !rst;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_ram[w_clr_idx] <= '0;
    end else if (w_we) begin
      r_ram[bus.REG_wa] <= bus.REG_wd;
    end
  end

  always_comb begin
    bus.REG_rs = '0;
    for (int p = 0; p < NRD; p++) begin
      if (!w_busy && (bus.REG_adr[p] != '0)) begin
        if (BYPASS && bus.REG_enable && (bus.REG_wa == bus.REG_adr[p])) begin
          bus.REG_rs[p] = bus.REG_wd;
        end else begin
          bus.REG_rs[p] = r_ram[bus.REG_adr[p]];
        end
      end
    end
  end

  assign bus.REG_busy = w_busy;

endmodule
